eth_udp_tx: RTL and testbench
=============================

# eth_udp_tx

Builds and transmits one Ethernet II / IPv4 / UDP frame for each request. It emits preamble, SFD, all headers, the payload streamed from the user side, zero padding and the FCS as a byte stream to the RMII serializer. It is the transmit-side counterpart of the receive parser and sits between user logic and the LAN8720 byte serializer. The IPv4 header checksum and the CRC-32 are computed in-block; the UDP checksum is sent as 0x0000.

## Interface
- FPGA_MAC, 48'h00_1A_2B_3C_4D_5E: source MAC address.
- FPGA_IP, 32'hC0_00_02_92: source IP address.
- FPGA_PORT, 16'd5005: source UDP port.
- IFG_CYCLES, 48: clocks tx_valid is held low after the last FCS byte (12 byte-times at 4 clk/byte).

Ports:
- clk  in  1  50 MHz LAN8720 clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request pulse; the destination fields and payload_len are sampled on the same edge.
- dest_mac  in  48  destination MAC address.
- dest_ip  in  32  destination IP address.
- dest_port  in  16  destination UDP port.
- payload_len  in  16  payload byte count; legal range 1..1472.
- busy  out  1  high from the accepted start through the end of the IFG.
- len_error  out  1  one-cycle pulse when start is rejected for an illegal length.
- payload_byte  in  8  payload data.
- payload_valid  in  1  payload_byte is valid.
- payload_ready  out  1  payload byte is consumed when payload_valid && payload_ready.
- tx_byte  out  8  byte to the serializer.
- tx_valid  out  1  tx_byte is held valid.
- tx_ready  in  1  serializer accepts tx_byte when tx_valid && tx_ready.
- tx_done  out  1  one-cycle pulse on acceptance of the last FCS byte.
- tx_underrun  out  1  one-cycle pulse the first time payload_valid is low during PAYLOAD while the output register is empty.

## Operation
- State sequence: IDLE → CSUM → PREAMBLE → ETH_HEADER → IP_HEADER → UDP_HEADER → PAYLOAD → PAD → FCS → IFG → IDLE.
- PAD is skipped when payload_len ≥ 18.
- IDLE:
  - start with payload_len of 0 or >1472: pulse len_error, remain in IDLE.
  - start with a legal length: latch the inputs, go to CSUM.
  - start while busy is high is ignored.
- CSUM:
  - Accumulates the 9 header words (all except the checksum) into a 32-bit sum, one word per cycle.
  - On the 10th cycle, folds the carries twice and inverts the result into the header checksum.
- PREAMBLE: 7×0x55, then 0xD5.
- ETH_HEADER: dest_mac, then FPGA_MAC, then 0x0800; each field MSB byte first.
- IP_HEADER, in transmit order:
  - 0x45, 0x00
  - total_len = 28 + payload_len
  - identification: 16-bit frame counter, reset to 0, incremented after each tx_done
  - 0x40 0x00 (DF set)
  - TTL 0x40, protocol 0x11
  - checksum
  - FPGA_IP, then dest_ip
- UDP_HEADER: FPGA_PORT, dest_port, udp_len = 8 + payload_len, checksum 0x0000.
- PAYLOAD: payload_len bytes, passed through from the payload interface.
- PAD: zero bytes until the Ethernet payload reaches 46 bytes, i.e. 18 − payload_len zeros.
- FCS CRC-32:
  - Reflected polynomial 0x04C11DB7, initial value 0xFFFFFFFF.
  - Covers the bytes from dest_mac through PAD.
  - Final value is inverted and sent LSB byte first.
- IFG: tx_valid stays low for IFG_CYCLES clocks, then the block returns to IDLE with busy low.
- Reset asserted mid-frame: the next edge forces IDLE, and the frame is abandoned without an FCS.

## Timing
- Reset values: tx_valid 0, tx_byte 0x00, payload_ready 0, busy 0, len_error 0, tx_done 0, tx_underrun 0, identification 0, state IDLE.
- Output register:
  - tx_byte/tx_valid are registered.
  - When a byte is accepted, the next byte is loaded on the same edge, so back-to-back transfers run with no bubble while tx_ready stays high.
  - tx_byte must not change while tx_valid && !tx_ready.
- Latency: the first 0x55 appears with tx_valid high on the 11th rising edge after the accepting start edge.
- payload_ready = (state == PAYLOAD) && (!tx_valid || tx_ready). This is combinational from tx_ready, and payload_ready is never high outside PAYLOAD.
- Underrun: the frame stalls with tx_valid low and resumes when payload_valid returns. Upstream must avoid this, because the PHY corrupts the frame.
- Total bytes on the wire = 8 + 14 + 28 + max(payload_len, 18) + 4.

## Structure
- eth_types_pkg gains:
  - Transmit state enum eth_tx_states.
  - Constants ETHERTYPE_IPV4 = 16'h0800, IP_PROTO_UDP = 8'h11, IP_TTL = 8'h40, ETH_MIN_PAYLOAD = 46, UDP_MAX_PAYLOAD = 1472.
  - The existing frame_header, ip_header and udp_header structs, reused for the latched header.
- Sub-module eth_crc32:
  - Ports: clk, resetn, init, en, data[7:0], crc[31:0].
  - Byte-wise, one byte per cycle.
  - The receive path reuses it for FCS checking.

## Test plan
- FPGA_IP = C0A80001, dest_ip = C0A800C7, payload_len = 87, first frame → IP header 45 00 00 73 00 00 40 00 40 11 B8 61, UDP length 0x005F, 141 bytes total, tx_done after the last byte.
- payload_len = 1, payload 0xAB → 17 zero PAD bytes, 72 bytes total; running CRC over dest_mac..FCS leaves residue 0xDEBB20E3.
- tx_ready toggled randomly → stream identical to the tx_ready = 1 run; tx_byte stable while stalled; payload is never dropped or duplicated.
- start with payload_len = 0 and then 1473 → len_error pulses each time, busy stays 0, no tx_valid. A second start during busy → ignored.
- Two back-to-back frames → identification 0x0000 then 0x0001, with at least 48 clk of tx_valid low between them.
- resetn low during PAYLOAD → next edge: tx_valid 0, busy 0; a following start produces a correct frame with identification 0.

Source files
------------

// File: rtl/eth_types_pkg.sv
// rtl/eth_types_pkg.sv - shared Ethernet/IPv4/UDP types and constants
package eth_types_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
    localparam logic [7:0]  IP_TTL          = 8'h40;
    localparam int          ETH_MIN_PAYLOAD = 46;
    localparam int          UDP_MAX_PAYLOAD = 1472;
    localparam int          IP_HDR_BYTES    = 20;
    localparam int          UDP_HDR_BYTES   = 8;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_CSUM,
        TX_PREAMBLE,
        TX_ETH_HEADER,
        TX_IP_HEADER,
        TX_UDP_HEADER,
        TX_PAYLOAD,
        TX_PAD,
        TX_FCS,
        TX_IFG
    } eth_tx_states;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
    } frame_header;

    typedef struct packed {
        logic [7:0]  version_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] ident;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] checksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ip_header;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_header;

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - byte-wise reflected CRC-32 register, shared by tx FCS generation and rx FCS check
module eth_crc32 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    import eth_types_pkg::*;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC32_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc <= '1;
        end else if (init) begin
            crc <= '1;
        end else if (en) begin
            crc <= crc_next(crc, data);
        end
    end

endmodule

// File: rtl/eth_udp_tx.sv
// rtl/eth_udp_tx.sv - Ethernet II / IPv4 / UDP frame builder feeding the RMII byte serializer
module eth_udp_tx #(
    parameter logic [47:0] FPGA_MAC   = 48'h00_1A_2B_3C_4D_5E,
    parameter logic [31:0] FPGA_IP    = 32'hC0_00_02_92,
    parameter logic [15:0] FPGA_PORT  = 16'd5005,
    parameter int          IFG_CYCLES = 48
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [47:0] dest_mac,
    input  logic [31:0] dest_ip,
    input  logic [15:0] dest_port,
    input  logic [15:0] payload_len,
    output logic        busy,
    output logic        len_error,
    input  logic [7:0]  payload_byte,
    input  logic        payload_valid,
    output logic        payload_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_done,
    output logic        tx_underrun
);
    import eth_types_pkg::*;

    localparam logic [15:0] MIN_UDP_PAYLOAD = 16'(ETH_MIN_PAYLOAD - IP_HDR_BYTES - UDP_HDR_BYTES);
    localparam logic [15:0] MAX_LEN         = 16'(UDP_MAX_PAYLOAD);
    localparam logic [15:0] IP_LEN_ADD      = 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
    localparam logic [15:0] UDP_LEN_ADD     = 16'(UDP_HDR_BYTES);
    localparam logic [15:0] IFG_LAST        = 16'(IFG_CYCLES - 1);

    eth_tx_states     state;
    frame_header      eth_h;
    ip_header         ip_h;
    udp_header        udp_h;
    logic [15:0]      len_q;
    logic [15:0]      cnt;
    logic [15:0]      frame_id;
    logic [31:0]      sum;
    logic             underrun_seen;
    logic [41:0][7:0] hdr;
    logic [5:0]       hdr_idx;
    logic [15:0]      csum_word;
    logic [16:0]      fold1;
    logic [15:0]      fold2;
    logic [31:0]      crc;
    logic [31:0]      fcs;
    logic             crc_init;
    logic             crc_en;
    logic             can_load;
    logic             have_byte;
    logic             load;
    logic [7:0]       next_byte;

    // All three headers packed in wire order; byte 41 is the first dest_mac byte.
    assign hdr     = {eth_h, ip_h, udp_h};
    assign hdr_idx = 6'd41 - cnt[5:0];
    assign fcs     = ~crc;

    always_comb begin
        csum_word = 16'h0000;
        case (cnt[3:0])
            4'd0: csum_word = {ip_h.version_ihl, ip_h.tos};
            4'd1: csum_word = ip_h.total_len;
            4'd2: csum_word = ip_h.ident;
            4'd3: csum_word = ip_h.flags_frag;
            4'd4: csum_word = {ip_h.ttl, ip_h.protocol};
            4'd5: csum_word = ip_h.src_ip[31:16];
            4'd6: csum_word = ip_h.src_ip[15:0];
            4'd7: csum_word = ip_h.dst_ip[31:16];
            4'd8: csum_word = ip_h.dst_ip[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    assign fold1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    assign fold2 = fold1[15:0] + {15'h0, fold1[16]};

    always_comb begin
        next_byte = 8'h00;
        have_byte = 1'b0;
        case (state)
            TX_PREAMBLE: begin
                have_byte = 1'b1;
                next_byte = (cnt == 16'd7) ? 8'hD5 : 8'h55;
            end
            TX_ETH_HEADER, TX_IP_HEADER, TX_UDP_HEADER: begin
                have_byte = 1'b1;
                next_byte = hdr[hdr_idx];
            end
            TX_PAYLOAD: begin
                have_byte = payload_valid;
                next_byte = payload_byte;
            end
            TX_PAD: have_byte = 1'b1;
            TX_FCS: begin
                have_byte = (cnt < 16'd4);
                case (cnt[1:0])
                    2'd0: next_byte = fcs[7:0];
                    2'd1: next_byte = fcs[15:8];
                    2'd2: next_byte = fcs[23:16];
                    default: next_byte = fcs[31:24];
                endcase
            end
            default: ;
        endcase
    end

    // A new byte enters the output register whenever it is empty or being drained this edge.
    assign can_load      = !tx_valid || tx_ready;
    assign load          = can_load && have_byte;
    assign payload_ready = (state == TX_PAYLOAD) && can_load;
    assign crc_init      = (state == TX_IDLE);
    assign crc_en        = load && (state inside {TX_ETH_HEADER, TX_IP_HEADER, TX_UDP_HEADER,
                                                  TX_PAYLOAD, TX_PAD});

    eth_crc32 u_crc (
        .clk    (clk),
        .resetn (resetn),
        .init   (crc_init),
        .en     (crc_en),
        .data   (next_byte),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= TX_IDLE;
            tx_byte       <= 8'h00;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            len_error     <= 1'b0;
            tx_done       <= 1'b0;
            tx_underrun   <= 1'b0;
            frame_id      <= 16'h0000;
            cnt           <= 16'h0000;
            len_q         <= 16'h0000;
            sum           <= 32'h0;
            underrun_seen <= 1'b0;
            eth_h         <= '0;
            ip_h          <= '0;
            udp_h         <= '0;
        end else begin
            len_error   <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;

            if (load) begin
                tx_byte  <= next_byte;
                tx_valid <= 1'b1;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            case (state)
                TX_IDLE: begin
                    if (start) begin
                        if (payload_len == 16'd0 || payload_len > MAX_LEN) begin
                            len_error <= 1'b1;
                        end else begin
                            eth_h <= '{dst_mac: dest_mac, src_mac: FPGA_MAC,
                                       ethertype: ETHERTYPE_IPV4};
                            ip_h  <= '{version_ihl: 8'h45, tos: 8'h00,
                                       total_len: payload_len + IP_LEN_ADD,
                                       ident: frame_id, flags_frag: 16'h4000,
                                       ttl: IP_TTL, protocol: IP_PROTO_UDP,
                                       checksum: 16'h0000, src_ip: FPGA_IP, dst_ip: dest_ip};
                            udp_h <= '{src_port: FPGA_PORT, dst_port: dest_port,
                                       length: payload_len + UDP_LEN_ADD, checksum: 16'h0000};
                            len_q         <= payload_len;
                            sum           <= 32'h0;
                            cnt           <= 16'h0000;
                            underrun_seen <= 1'b0;
                            busy          <= 1'b1;
                            state         <= TX_CSUM;
                        end
                    end
                end
                TX_CSUM: begin
                    if (cnt == 16'd9) begin
                        ip_h.checksum <= ~fold2;
                        cnt           <= 16'h0000;
                        state         <= TX_PREAMBLE;
                    end else begin
                        sum <= sum + {16'h0000, csum_word};
                        cnt <= cnt + 16'd1;
                    end
                end
                TX_PREAMBLE: begin
                    if (load) begin
                        if (cnt == 16'd7) begin
                            cnt   <= 16'h0000;
                            state <= TX_ETH_HEADER;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                TX_ETH_HEADER: begin
                    if (load) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == 16'd13) state <= TX_IP_HEADER;
                    end
                end
                TX_IP_HEADER: begin
                    if (load) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == 16'd33) state <= TX_UDP_HEADER;
                    end
                end
                TX_UDP_HEADER: begin
                    if (load) begin
                        if (cnt == 16'd41) begin
                            cnt   <= 16'h0000;
                            state <= TX_PAYLOAD;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                TX_PAYLOAD: begin
                    if (!payload_valid && !tx_valid && !underrun_seen) begin
                        tx_underrun   <= 1'b1;
                        underrun_seen <= 1'b1;
                    end
                    if (load) begin
                        if (cnt == len_q - 16'd1) begin
                            if (len_q < MIN_UDP_PAYLOAD) begin
                                cnt   <= cnt + 16'd1;
                                state <= TX_PAD;
                            end else begin
                                cnt   <= 16'h0000;
                                state <= TX_FCS;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                TX_PAD: begin
                    // cnt carries on from the payload count, so padding stops at the 46-byte minimum.
                    if (load) begin
                        if (cnt == MIN_UDP_PAYLOAD - 16'd1) begin
                            cnt   <= 16'h0000;
                            state <= TX_FCS;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                TX_FCS: begin
                    if (cnt < 16'd4) begin
                        if (load) cnt <= cnt + 16'd1;
                    end else if (tx_valid && tx_ready) begin
                        tx_done  <= 1'b1;
                        frame_id <= frame_id + 16'd1;
                        cnt      <= 16'h0000;
                        state    <= TX_IFG;
                    end
                end
                TX_IFG: begin
                    if (cnt == IFG_LAST) begin
                        busy  <= 1'b0;
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_udp_tx.sv
// tb/tb_eth_udp_tx.sv - directed self-checking bench for eth_udp_tx
module tb_eth_udp_tx;

    localparam logic [47:0] FPGA_MAC  = 48'h001A2B3C4D5E;
    localparam logic [31:0] FPGA_IP   = 32'hC0A80001;
    localparam logic [15:0] FPGA_PORT = 16'd5005;
    localparam logic [31:0] DIP       = 32'hC0A800C7;
    localparam logic [47:0] DMAC      = 48'h020000000001;
    localparam logic [15:0] DPORT     = 16'd4000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [47:0] dest_mac = '0;
    logic [31:0] dest_ip = '0;
    logic [15:0] dest_port = '0;
    logic [15:0] payload_len = '0;
    logic        busy, len_error, payload_ready, tx_valid, tx_done, tx_underrun;
    logic [7:0]  tx_byte;
    logic [7:0]  payload_byte = 8'h00;
    logic        payload_valid = 1'b0;
    logic        tx_ready = 1'b1;

    always #10 clk = ~clk;

    eth_udp_tx #(.FPGA_MAC(FPGA_MAC), .FPGA_IP(FPGA_IP), .FPGA_PORT(FPGA_PORT), .IFG_CYCLES(48)) dut (
        .clk(clk), .resetn(resetn), .start(start), .dest_mac(dest_mac), .dest_ip(dest_ip),
        .dest_port(dest_port), .payload_len(payload_len), .busy(busy), .len_error(len_error),
        .payload_byte(payload_byte), .payload_valid(payload_valid), .payload_ready(payload_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
        .tx_underrun(tx_underrun)
    );

    int tests = 0;
    int fails = 0;

    task automatic expect_eq(input string tag, input logic [95:0] got, input logic [95:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    logic [7:0] pay [$];
    logic [7:0] cap [$];
    logic [7:0] exp_q [$];
    int  plen = 0, pidx = 0, gap_at = -1, gap_left = 0;
    bit  rand_ready = 1'b0;
    int  done_at = 0, under_cnt = 0, stall_err = 0, low_run = 0, last_gap = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    // Source, sink and monitor: drive on the falling edge, observe 1 ns later.
    always @(negedge clk) begin
        tx_ready      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        payload_byte  = (pidx < plen) ? pay[pidx] : 8'h00;
        payload_valid = (pidx < plen) && !(pidx == gap_at && gap_left > 0);
        if (pidx == gap_at && gap_left > 0) gap_left--;
        #1;
        if (prev_stall && (!tx_valid || tx_byte !== prev_byte)) stall_err++;
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
        if (payload_valid && payload_ready) pidx++;
        if (tx_valid && tx_ready) cap.push_back(tx_byte);
        if (tx_valid) begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
        if (tx_done) done_at = cap.size();
        if (tx_underrun) under_cnt++;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        c = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic push16(input logic [15:0] v);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
    endtask

    task automatic build_exp(input logic [47:0] dmac, input logic [31:0] dip,
                             input logic [15:0] dport, input int len, input logic [15:0] ident);
        logic [31:0] s, c;
        logic [15:0] tot;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(FPGA_MAC[8*i +: 8]);
        push16(16'h0800);
        tot = 16'(28 + len);
        s = 32'h4500 + tot + ident + 32'h4000 + 32'h4011 + FPGA_IP[31:16] + FPGA_IP[15:0]
            + dip[31:16] + dip[15:0];
        s = s[15:0] + s[31:16];
        s = s[15:0] + s[31:16];
        push16(16'h4500); push16(tot); push16(ident); push16(16'h4000); push16(16'h4011);
        push16(~s[15:0]);
        push16(FPGA_IP[31:16]); push16(FPGA_IP[15:0]); push16(dip[31:16]); push16(dip[15:0]);
        push16(FPGA_PORT); push16(dport); push16(16'(8 + len)); push16(16'h0000);
        for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
        for (int i = len; i < 18; i++) exp_q.push_back(8'h00);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endtask

    function automatic logic [95:0] cap_bytes(input int off, input int n);
        logic [95:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[87:0], (off + i < cap.size()) ? cap[off + i] : 8'h00};
        return v;
    endfunction

    task automatic fill_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    task automatic start_frame(input logic [47:0] dmac, input logic [31:0] dip,
                               input logic [15:0] dport, input int len, input string tag);
        int k;
        cap.delete();
        done_at     = 0;
        plen        = len;
        pidx        = 0;
        dest_mac    = dmac;
        dest_ip     = dip;
        dest_port   = dport;
        payload_len = 16'(len);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        expect_eq({tag, " busy after start"}, busy, 1);
        while (!tx_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        expect_eq({tag, " first byte latency"}, k, 12);
    endtask

    task automatic wait_frame(input string tag);
        int k = 0;
        int errs = 0;
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        expect_eq({tag, " frame finished"}, busy, 0);
        expect_eq({tag, " byte count"}, cap.size(), exp_q.size());
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) errs++;
        expect_eq({tag, " frame bytes"}, errs, 0);
        expect_eq({tag, " tx_done position"}, done_at, exp_q.size());
    endtask

    initial begin
        int k;
        int zeros;
        logic [31:0] r;
        logic [15:0] lens [2];

        repeat (3) @(negedge clk);
        expect_eq("reset tx_valid", tx_valid, 0);
        expect_eq("reset tx_byte", tx_byte, 8'h00);
        expect_eq("reset payload_ready", payload_ready, 0);
        expect_eq("reset busy", busy, 0);
        expect_eq("reset len_error", len_error, 0);
        expect_eq("reset tx_done", tx_done, 0);
        expect_eq("reset tx_underrun", tx_underrun, 0);
        resetn = 1'b1;
        @(negedge clk);

        lens[0] = 16'd0;
        lens[1] = 16'd1473;
        cap.delete();
        for (int i = 0; i < 2; i++) begin
            payload_len = lens[i];
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            expect_eq($sformatf("len_error len=%0d", lens[i]), len_error, 1);
            expect_eq($sformatf("busy after bad len=%0d", lens[i]), busy, 0);
            @(negedge clk);
            expect_eq($sformatf("len_error single pulse len=%0d", lens[i]), len_error, 0);
        end
        repeat (20) @(negedge clk);
        expect_eq("bad len no tx bytes", cap.size(), 0);
        expect_eq("bad len still idle", busy, 0);

        // Frame A: header contents against hand-computed values
        fill_pay(87);
        build_exp(DMAC, DIP, DPORT, 87, 16'h0000);
        start_frame(DMAC, DIP, DPORT, 87, "A");
        wait_frame("A");
        expect_eq("A ip header", cap_bytes(22, 12), 96'h45000073000040004011B861);
        expect_eq("A udp length", cap_bytes(46, 2), 16'h005F);
        expect_eq("A total bytes", cap.size(), 141);

        // Frame B back-to-back: minimum payload with padding
        pay.delete();
        pay.push_back(8'hAB);
        build_exp(DMAC, DIP, DPORT, 1, 16'h0001);
        start_frame(DMAC, DIP, DPORT, 1, "B");
        wait_frame("B");
        expect_eq("B identification", cap_bytes(26, 2), 16'h0001);
        expect_eq("B total bytes", cap.size(), 72);
        expect_eq("B payload byte", cap_bytes(50, 1), 8'hAB);
        zeros = 0;
        for (int i = 51; i < 68 && i < cap.size(); i++) if (cap[i] == 8'h00) zeros++;
        expect_eq("B pad zeros", zeros, 17);
        r = 32'hFFFFFFFF;
        for (int i = 8; i < cap.size(); i++) r = crc_upd(r, cap[i]);
        expect_eq("B crc residue", r, 32'hDEBB20E3);
        expect_eq("A-B interframe gap >= 48", last_gap >= 48, 1);

        // Frame C: random backpressure, 18-byte payload, plus a start while busy
        stall_err  = 0;
        rand_ready = 1'b1;
        fill_pay(18);
        build_exp(48'hFFFFFFFFFFFF, 32'h0A000001, 16'd53, 18, 16'h0002);
        start_frame(48'hFFFFFFFFFFFF, 32'h0A000001, 16'd53, 18, "C");
        payload_len = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frame("C");
        rand_ready = 1'b0;
        expect_eq("C total bytes", cap.size(), 72);
        expect_eq("C tx_byte stable while stalled", stall_err, 0);
        expect_eq("C payload consumed exactly", pidx, 18);
        repeat (100) @(negedge clk);
        expect_eq("start during busy ignored (busy)", busy, 0);
        expect_eq("start during busy ignored (bytes)", cap.size(), 72);
        expect_eq("no underrun with steady payload", under_cnt, 0);

        // Frame D: payload gap causes a single underrun pulse
        under_cnt = 0;
        gap_at    = 10;
        gap_left  = 8;
        fill_pay(30);
        build_exp(DMAC, DIP, DPORT, 30, 16'h0003);
        start_frame(DMAC, DIP, DPORT, 30, "D");
        wait_frame("D");
        gap_at = -1;
        expect_eq("D underrun pulses", under_cnt, 1);

        // Frame E: reset during payload
        fill_pay(100);
        start_frame(DMAC, DIP, DPORT, 100, "E");
        k = 0;
        while (pidx < 10 && k < 500) begin
            @(negedge clk);
            k++;
        end
        expect_eq("E reached payload", pidx >= 10, 1);
        resetn = 1'b0;
        @(negedge clk);
        expect_eq("E reset tx_valid", tx_valid, 0);
        expect_eq("E reset busy", busy, 0);
        expect_eq("E reset payload_ready", payload_ready, 0);
        resetn = 1'b1;
        plen   = 0;
        @(negedge clk);

        // Frame F: identification restarts at 0 after reset
        fill_pay(87);
        build_exp(DMAC, DIP, DPORT, 87, 16'h0000);
        start_frame(DMAC, DIP, DPORT, 87, "F");
        wait_frame("F");
        expect_eq("F identification", cap_bytes(26, 2), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
